spm_mem_ctrl: RTL and testbench



---
 rtl/spm_mem_ctrl.sv | 173 +++++++++++++++++
 tb/tb_spm_mem_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spm_mem_ctrl.sv
// MEM-stage controller for scratch-pad port B: word accesses, sub-word load
// extension, read-modify-write for byte/halfword stores, misalignment detection.
module spm_mem_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_en,
   input  logic [3:0]  mem_op,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        stall,
   output logic        miss_align,
   output logic [11:0] spm_addr,
   output logic        spm_as_,
   output logic        spm_rw,
   output logic [31:0] spm_wr_data,
   input  logic [31:0] spm_rd_data
);

   localparam logic       SPM_READ  = 1'b1;
   localparam logic       SPM_WRITE = 1'b0;
   localparam logic [3:0] OP_LW  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LHU = 4'd3;
   localparam logic [3:0] OP_LB  = 4'd4;
   localparam logic [3:0] OP_LBU = 4'd5;
   localparam logic [3:0] OP_SW  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SB  = 4'd8;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      LOAD_WAIT   = 2'd1,
      STORE_MERGE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [13:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;

   // Address bits above the SPM window are intentionally ignored.
   logic unused_addr_s;
   assign unused_addr_s = ^{addr[31:14], wr_data[31:16]};

   function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lane);
      case (op)
         OP_LW, OP_SW:         is_misaligned = (lane != 2'd0);
         OP_LH, OP_LHU, OP_SH: is_misaligned = lane[0];
         default:              is_misaligned = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] lane,
                                               input logic [31:0] word);
      logic [31:0] shifted;
      shifted = word >> {lane, 3'b000};
      case (op)
         OP_LW:   load_extend = word;
         OP_LH:   load_extend = {{16{shifted[15]}}, shifted[15:0]};
         OP_LHU:  load_extend = {16'h0000, shifted[15:0]};
         OP_LB:   load_extend = {{24{shifted[7]}}, shifted[7:0]};
         OP_LBU:  load_extend = {24'h000000, shifted[7:0]};
         default: load_extend = 32'h0000_0000;
      endcase
   endfunction

   function automatic logic [31:0] merge_lane(input logic [3:0] op, input logic [1:0] lane,
                                              input logic [31:0] old_word, input logic [15:0] data);
      logic [31:0] base_mask;
      logic [31:0] lane_mask;
      if (op == OP_SH) begin
         base_mask = 32'h0000_FFFF;
      end else begin
         base_mask = 32'h0000_00FF;
      end
      lane_mask  = base_mask << {lane, 3'b000};
      merge_lane = (old_word & ~lane_mask) |
                   (({16'h0000, data} & base_mask) << {lane, 3'b000});
   endfunction

   // State register and request latch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         op_q    <= 4'd0;
         addr_q  <= 14'd0;
         wdata_q <= 16'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Next-state, request capture and all SPM/pipeline outputs.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rd_data     = 32'h0000_0000;
      stall       = 1'b0;
      miss_align  = 1'b0;
      spm_addr    = 12'd0;
      spm_as_     = 1'b1;
      spm_rw      = SPM_READ;
      spm_wr_data = 32'h0000_0000;
      if (!reset) begin
         // Outputs held idle while reset is asserted so no stray strobe escapes.
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_en && is_misaligned(mem_op, addr[1:0])) begin
                  miss_align = 1'b1;
               end else if (req_en) begin
                  case (mem_op)
                     OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
                        spm_as_  = 1'b0;
                        spm_addr = addr[13:2];
                        stall    = 1'b1;
                        op_d     = mem_op;
                        addr_d   = addr[13:0];
                        wdata_d  = wr_data[15:0];
                        state_d  = LOAD_WAIT;
                     end
                     OP_SW: begin
                        spm_as_     = 1'b0;
                        spm_rw      = SPM_WRITE;
                        spm_addr    = addr[13:2];
                        spm_wr_data = wr_data;
                        op_d        = mem_op;
                        addr_d      = addr[13:0];
                        wdata_d     = wr_data[15:0];
                     end
                     OP_SH, OP_SB: begin
                        spm_as_  = 1'b0;
                        spm_addr = addr[13:2];
                        stall    = 1'b1;
                        op_d     = mem_op;
                        addr_d   = addr[13:0];
                        wdata_d  = wr_data[15:0];
                        state_d  = STORE_MERGE;
                     end
                     default: begin
                        state_d = IDLE;
                     end
                  endcase
               end else begin
                  state_d = IDLE;
               end
            end
            LOAD_WAIT: begin
               rd_data = load_extend(op_q, addr_q[1:0], spm_rd_data);
               state_d = IDLE;
            end
            STORE_MERGE: begin
               spm_as_     = 1'b0;
               spm_rw      = SPM_WRITE;
               spm_addr    = addr_q[13:2];
               spm_wr_data = merge_lane(op_q, addr_q[1:0], spm_rd_data, wdata_q);
               state_d     = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spm_mem_ctrl.sv
// Self-checking bench for spm_mem_ctrl: directed table, reset corner cases and
// randomized ops against a word-array reference model.
module tb_spm_mem_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_en = 1'b0;
   logic [3:0]  mem_op = 4'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wr_data = 32'd0;
   logic [31:0] rd_data;
   logic        stall;
   logic        miss_align;
   logic [11:0] spm_addr;
   logic        spm_as_;
   logic        spm_rw;
   logic [31:0] spm_wr_data;
   logic [31:0] spm_rd_data = 32'd0;

   int checks = 0;
   int errors = 0;

   logic [31:0] spm_mem [0:4095];
   logic [31:0] ref_mem [0:4095];

   spm_mem_ctrl dut (
      .clk(clk), .reset(reset), .req_en(req_en), .mem_op(mem_op), .addr(addr),
      .wr_data(wr_data), .rd_data(rd_data), .stall(stall), .miss_align(miss_align),
      .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
      .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data)
   );

   always #5 clk = ~clk;

   // Scratch-pad port B model: synchronous write, one-cycle read latency.
   always @(posedge clk) begin
      if (!spm_as_) begin
         if (spm_rw == 1'b0) spm_mem[spm_addr] <= spm_wr_data;
         else                spm_rd_data <= spm_mem[spm_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Issue one request and check every cycle of it against the reference model.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] obs, output logic obs_miss);
      int          widx;
      int          shamt;
      logic [31:0] w, s, exp_v, mask;
      bit          is_load, is_sub, mis;
      widx    = (a % 32'h4000) / 4;
      shamt   = 8 * (a % 4);
      is_load = (op >= 4'd1 && op <= 4'd5);
      is_sub  = (op == 4'd7 || op == 4'd8);
      mis     = ((op == 4'd1 || op == 4'd6) && (a % 4) != 0) ||
                ((op == 4'd2 || op == 4'd3 || op == 4'd7) && (a % 2) != 0);
      @(negedge clk);
      req_en = 1'b1; mem_op = op; addr = a; wr_data = d;
      #1;
      obs = 32'd0;
      obs_miss = miss_align;
      if (mis) begin
         chk("mis_flag", {31'd0, miss_align}, 32'd1);
         chk("mis_as", {31'd0, spm_as_}, 32'd1);
         chk("mis_stall", {31'd0, stall}, 32'd0);
      end else if (op == 4'd0 || op > 4'd8) begin
         chk("nop_as", {31'd0, spm_as_}, 32'd1);
         chk("nop_stall", {31'd0, stall}, 32'd0);
         chk("nop_addr", {20'd0, spm_addr}, 32'd0);
         chk("nop_miss", {31'd0, miss_align}, 32'd0);
      end else if (op == 4'd6) begin
         chk("sw_as", {31'd0, spm_as_}, 32'd0);
         chk("sw_rw", {31'd0, spm_rw}, 32'd0);
         chk("sw_addr", {20'd0, spm_addr}, widx);
         chk("sw_data", spm_wr_data, d);
         chk("sw_stall", {31'd0, stall}, 32'd0);
         obs = spm_wr_data;
         ref_mem[widx] = d;
      end else begin
         chk("rd1_as", {31'd0, spm_as_}, 32'd0);
         chk("rd1_rw", {31'd0, spm_rw}, 32'd1);
         chk("rd1_addr", {20'd0, spm_addr}, widx);
         chk("rd1_stall", {31'd0, stall}, 32'd1);
         chk("rd1_rdata", rd_data, 32'd0);
      end
      if (is_load && !mis) begin
         @(negedge clk);
         w = ref_mem[widx];
         s = w >> shamt;
         case (op)
            4'd1:    exp_v = w;
            4'd2:    exp_v = 32'($signed(s[15:0]));
            4'd3:    exp_v = s & 32'h0000_FFFF;
            4'd4:    exp_v = 32'($signed(s[7:0]));
            default: exp_v = s & 32'h0000_00FF;
         endcase
         chk("ld_rdata", rd_data, exp_v);
         chk("ld_stall", {31'd0, stall}, 32'd0);
         chk("ld_as", {31'd0, spm_as_}, 32'd1);
         obs = rd_data;
      end else if (is_sub && !mis) begin
         @(negedge clk);
         mask  = ((op == 4'd7) ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
         exp_v = (ref_mem[widx] & ~mask) | ((d << shamt) & mask);
         chk("st_as", {31'd0, spm_as_}, 32'd0);
         chk("st_rw", {31'd0, spm_rw}, 32'd0);
         chk("st_addr", {20'd0, spm_addr}, widx);
         chk("st_data", spm_wr_data, exp_v);
         chk("st_stall", {31'd0, stall}, 32'd0);
         ref_mem[widx] = exp_v;
         obs = spm_wr_data;
      end
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp;
      logic        exp_miss;
      logic        chk_val;
   } vec_t;

   vec_t tbl [0:14];

   initial begin
      logic [31:0] obs;
      logic        om;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 32'd0;

      tbl[0]  = '{4'd6, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1};
      tbl[1]  = '{4'd1, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b1};
      tbl[2]  = '{4'd6, 32'h0000_0020, 32'h80F1_7F22, 32'h80F1_7F22, 1'b0, 1'b1};
      tbl[3]  = '{4'd4, 32'h0000_0023, 32'h0000_0000, 32'hFFFF_FF80, 1'b0, 1'b1};
      tbl[4]  = '{4'd5, 32'h0000_0023, 32'h0000_0000, 32'h0000_0080, 1'b0, 1'b1};
      tbl[5]  = '{4'd2, 32'h0000_0022, 32'h0000_0000, 32'hFFFF_80F1, 1'b0, 1'b1};
      tbl[6]  = '{4'd3, 32'h0000_0020, 32'h0000_0000, 32'h0000_7F22, 1'b0, 1'b1};
      tbl[7]  = '{4'd6, 32'h0000_0024, 32'h1122_3344, 32'h1122_3344, 1'b0, 1'b1};
      tbl[8]  = '{4'd8, 32'h0000_0025, 32'h0000_00AB, 32'h1122_AB44, 1'b0, 1'b1};
      tbl[9]  = '{4'd6, 32'h0000_0028, 32'h1122_3344, 32'h1122_3344, 1'b0, 1'b1};
      tbl[10] = '{4'd7, 32'h0000_002A, 32'h0000_5566, 32'h5566_3344, 1'b0, 1'b1};
      tbl[11] = '{4'd1, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
      tbl[12] = '{4'd2, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
      tbl[13] = '{4'd7, 32'h0000_0003, 32'h0000_1234, 32'h0000_0000, 1'b1, 1'b0};
      tbl[14] = '{4'd1, 32'h0000_4010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b1};

      // Reset held with random inputs: outputs must stay idle.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_en = 1'($urandom); mem_op = 4'($urandom); addr = $urandom; wr_data = $urandom;
         #1;
         chk("rst_as", {31'd0, spm_as_}, 32'd1);
         chk("rst_stall", {31'd0, stall}, 32'd0);
         chk("rst_rdata", rd_data, 32'd0);
         chk("rst_miss", {31'd0, miss_align}, 32'd0);
      end
      @(negedge clk);
      req_en = 1'b0; reset = 1'b1;

      // Prefill the 16 words that all later traffic uses.
      for (int i = 0; i < 16; i++) do_op(4'd6, 32'(i * 4), $urandom, obs, om);

      for (int i = 0; i < 15; i++) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].d, obs, om);
         chk($sformatf("tbl%0d_miss", i), {31'd0, om}, {31'd0, tbl[i].exp_miss});
         if (tbl[i].chk_val) chk($sformatf("tbl%0d_val", i), obs, tbl[i].exp);
      end

      // Reset pulsed during the merge cycle must suppress the write.
      do_op(4'd6, 32'h0000_0030, 32'hCAFE_F00D, obs, om);
      @(negedge clk);
      req_en = 1'b1; mem_op = 4'd8; addr = 32'h0000_0031; wr_data = 32'h0000_0055;
      #1;
      chk("rm_stall", {31'd0, stall}, 32'd1);
      @(negedge clk);
      chk("rm_merge_as", {31'd0, spm_as_}, 32'd0);
      reset = 1'b0;
      #1;
      chk("rm_rst_as", {31'd0, spm_as_}, 32'd1);
      chk("rm_rst_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      req_en = 1'b0; reset = 1'b1;
      #1;
      chk("rm_idle_as", {31'd0, spm_as_}, 32'd1);
      chk("rm_idle_stall", {31'd0, stall}, 32'd0);
      do_op(4'd1, 32'h0000_0030, 32'd0, obs, om);
      chk("rm_word_kept", obs, 32'hCAFE_F00D);

      // Random traffic, including idle cycles and wrapped high address bits.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clk);
            req_en = 1'b0; mem_op = 4'($urandom); addr = $urandom;
            #1;
            chk("idle_as", {31'd0, spm_as_}, 32'd1);
            chk("idle_stall", {31'd0, stall}, 32'd0);
            chk("idle_rdata", rd_data, 32'd0);
         end else begin
            do_op(4'($urandom_range(0, 15)),
                  ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63)),
                  $urandom, obs, om);
         end
      end

      @(negedge clk);
      req_en = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 16; i++) chk($sformatf("mem%0d", i), spm_mem[i], ref_mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
